// File: rtl/rr_arb_32_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// slave = arbiter side (consumes requests, drives grants); master = requester side.
interface rr_arb_32_if #(
  parameter int N    = 32,
  parameter int IDXW = 5
);
  logic [N-1:0]    req;
  logic            done;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic [N-1:0]    grant;
  logic            preempt;

  modport slave (
    input  req, done,
    output grant_valid, grant_idx, grant, preempt
  );

  modport master (
    output req, done,
    input  grant_valid, grant_idx, grant, preempt
  );
endinterface

// File: rtl/rr_arb_32.sv
// Round-robin arbiter with grant hold-until-release and back-to-back re-arbitration.
// Optional hold limit with preempt pulse enabled by macro RR_ARB_HOLD_LIMIT_EN.
module rr_arb_32 #(
  parameter int N        = 32,
  parameter int IDXW     = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  rr_arb_32_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [IDXW:0]   N_W    = (IDXW+1)'(N);
  localparam logic [IDXW-1:0] N_LAST = IDXW'(N - 1);
  localparam logic [N-1:0]    ONE_N  = {{(N-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    grant_q, grant_d;

  logic [IDXW-1:0] ptr_rel;
  logic [IDXW-1:0] arb_ptr;
  logic [N-1:0]    arb_req;
  logic [IDXW:0]   cand;
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic            hold_hit;
  logic            release_w;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int              HOLDW     = $clog2(MAX_HOLD + 1);
  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MAX_HOLD - 1);

  logic [HOLDW-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;

  assign hold_hit    = (hold_q == HOLD_LAST);
  assign bus.preempt = preempt_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD != 0);
  assign hold_hit        = 1'b0;
  assign bus.preempt     = 1'b0;
`endif

  // While busy, arbitration already looks past the current grantee and never re-picks it.
  always_comb begin
    ptr_rel   = (idx_q == N_LAST) ? '0 : idx_q + 1'b1;
    release_w = bus.done | ~bus.req[idx_q] | hold_hit;
    arb_ptr   = (state_q == BUSY) ? ptr_rel : ptr_q;
    arb_req   = bus.req & ~((state_q == BUSY) ? (ONE_N << idx_q) : '0);
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, arb_ptr} + (IDXW+1)'(i);
      if (cand >= N_W) cand = cand - N_W;
      if (!win_found && arb_req[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    grant_d = grant_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          idx_d   = win_idx;
          valid_d = 1'b1;
          grant_d = ONE_N << win_idx;
        end
      end
      BUSY: begin
`ifdef RR_ARB_HOLD_LIMIT_EN
        hold_d = hold_q + 1'b1;
`endif
        if (release_w) begin
          ptr_d = ptr_rel;
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_d    = '0;
          preempt_d = hold_hit & ~bus.done & bus.req[idx_q];
`endif
          if (win_found) begin
            idx_d   = win_idx;
            grant_d = ONE_N << win_idx;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q    <= '0;
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
`endif
    end
  end

  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant       = grant_q;

endmodule

// File: tb/tb_rr_arb_32.sv
// Directed bench for rr_arb_32: reset, single grant, full rotation, wrap,
// hold behaviour (both builds) and reset mid-grant.
module tb_rr_arb_32;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  rr_arb_32_if #(.N(32), .IDXW(5)) bus ();

  rr_arb_32 #(.N(32), .IDXW(5), .MAX_HOLD(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {valid, idx, grant, preempt} against hand-supplied expectations.
  task automatic chk(input string tag, input logic v, input logic [4:0] idx,
                     input logic [31:0] g, input logic p);
    logic [38:0] obs;
    logic [38:0] exp_v;
    obs   = {bus.grant_valid, bus.grant_idx, bus.grant, bus.preempt};
    exp_v = {v, idx, g, p};
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got valid=%b idx=%0d grant=%h preempt=%b, expected valid=%b idx=%0d grant=%h preempt=%b",
             tag, obs[38], obs[37:33], obs[32:1], obs[0], v, idx, g, p);
    end
    $display("[TB] %s: valid=%b idx=%0d grant=%h preempt=%b", tag,
             bus.grant_valid, bus.grant_idx, bus.grant, bus.preempt);
  endtask

  initial begin
    logic [31:0] onehot;
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    bus.req  = 32'hFFFF_FFFF;
    bus.done = 1'b0;

    // 1. reset holds everything at zero despite full requests
    step(); chk("rst_cyc0", 1'b0, 5'd0, 32'h0, 1'b0);
    step(); chk("rst_cyc1", 1'b0, 5'd0, 32'h0, 1'b0);
    rst = 1'b0; bus.req = 32'h0;
    step(); chk("idle_after_rst", 1'b0, 5'd0, 32'h0, 1'b0);

    // 2. single requester, done, re-grant only through IDLE
    bus.req = 32'h0000_0008;
    step(); chk("single_grant3", 1'b1, 5'd3, 32'h0000_0008, 1'b0);
    step(); chk("single_hold3", 1'b1, 5'd3, 32'h0000_0008, 1'b0);
    bus.done = 1'b1;
    step(); chk("done_to_idle", 1'b0, 5'd0, 32'h0, 1'b0);
    bus.done = 1'b0;
    step(); chk("regrant_via_idle", 1'b1, 5'd3, 32'h0000_0008, 1'b0);
    bus.req = 32'h0;
    step(); chk("req_drop_idle", 1'b0, 5'd0, 32'h0, 1'b0);
    bus.done = 1'b1;
    step(); chk("done_idle_ignored", 1'b0, 5'd0, 32'h0, 1'b0);
    bus.done = 1'b0;

    // 3. full rotation with done every cycle, from ptr=0
    rst = 1'b1;
    step(); rst = 1'b0;
    bus.req = 32'hFFFF_FFFF; bus.done = 1'b1;
    step(); chk("rot_first0", 1'b1, 5'd0, 32'h0000_0001, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      step();
      onehot = 32'h1 << (i % 32);
      chk($sformatf("rot_%0d", i % 32), 1'b1, 5'(i % 32), onehot, 1'b0);
    end

    // 4. wrap: grant 30, then 31, then 2
    bus.done = 1'b0; bus.req = 32'h4000_0000;
    step(); chk("wrap_grant30", 1'b1, 5'd30, 32'h4000_0000, 1'b0);
    bus.req = 32'h8000_0004;
    step(); chk("wrap_grant31", 1'b1, 5'd31, 32'h8000_0000, 1'b0);
    bus.done = 1'b1;
    step(); chk("wrap_grant2", 1'b1, 5'd2, 32'h0000_0004, 1'b0);
    bus.done = 1'b0; bus.req = 32'h0;
    step(); chk("wrap_idle", 1'b0, 5'd0, 32'h0, 1'b0);

    // 5. hold behaviour, requesters 5 and 9, no done
    bus.req = 32'h0000_0220;
    for (int c = 0; c < 16; c++) begin
      step(); chk($sformatf("hold5_c%0d", c), 1'b1, 5'd5, 32'h0000_0020, 1'b0);
    end
`ifdef RR_ARB_HOLD_LIMIT_EN
    step(); chk("preempt_to9", 1'b1, 5'd9, 32'h0000_0200, 1'b1);
    step(); chk("preempt_clear", 1'b1, 5'd9, 32'h0000_0200, 1'b0);
`else
    for (int c = 16; c < 20; c++) begin
      step(); chk($sformatf("hold5_nolimit_c%0d", c), 1'b1, 5'd5, 32'h0000_0020, 1'b0);
    end
`endif
    bus.req = 32'h0;
    step(); chk("hold_idle", 1'b0, 5'd0, 32'h0, 1'b0);

    // 6. reset mid-grant, then ptr must be back at 0 (7 beats 8)
    bus.req = 32'h0000_0080;
    step(); chk("mid_grant7", 1'b1, 5'd7, 32'h0000_0080, 1'b0);
    rst = 1'b1;
    step(); chk("mid_rst_zero", 1'b0, 5'd0, 32'h0, 1'b0);
    rst = 1'b0; bus.req = 32'h0;
    step(); chk("post_rst_idle", 1'b0, 5'd0, 32'h0, 1'b0);
    bus.req = 32'h0000_0180;
    step(); chk("ptr_reset_grant7", 1'b1, 5'd7, 32'h0000_0080, 1'b0);
    bus.req = 32'h0000_0100;
    step(); chk("b2b_grant8", 1'b1, 5'd8, 32'h0000_0100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
